// File: rtl/belief_update_if.sv
// Request/table/result bundle between the observation generator, the
// belief update stage and the PBVI value/policy stage.
interface belief_update_if #(
    parameter int W = 16
);
    logic                            en_belief;
    logic [1:0]                      action;
    logic                            observation;
    logic [0:2][0:1][0:1][W-1:0]     observe;
    logic [0:2][0:1][0:1][W-1:0]     trans;
    logic                            belief_load;
    logic [W-1:0]                    belief_init;
    logic [W-1:0]                    belief_out;
    logic                            belief_valid;
    logic                            busy;
    logic                            degenerate;

    modport master (
        output en_belief, action, observation, observe, trans,
               belief_load, belief_init,
        input  belief_out, belief_valid, busy, degenerate
    );

    modport slave (
        input  en_belief, action, observation, observe, trans,
               belief_load, belief_init,
        output belief_out, belief_valid, busy, degenerate
    );
endinterface

// File: rtl/belief_update.sv
// One Bayesian belief update of P(state0) for a 2-state POMDP, using a single
// shared multiplier (PRED/UPD) and a restoring divider (DIV), 23-cycle latency.
module belief_update #(
    parameter int W         = 16,
    parameter int DIV_STEPS = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    belief_update_if.slave  bus
);
    localparam int PW = 2 * W;
    localparam int CW = $clog2(DIV_STEPS) + 1;

    typedef enum logic [1:0] {IDLE, PRED, UPD, DIV} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     act_q, act_d;
    logic           obs_q, obs_d;
    logic [W-1:0]   b0_q, b0_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   pred0_q, pred0_d;
    logic [W-1:0]   pred1_q, pred1_d;
    logic [W-1:0]   u0_q, u0_d;
    logic [W-1:0]   u1_q, u1_d;
    logic [W+1:0]   rem_q, rem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   belief_q, belief_d;
    logic           valid_q, valid_d;
    logic           degen_q, degen_d;

    logic [W:0]     b1;
    logic [W:0]     sum;
    logic [W:0]     acc_sum;
    logic [W-1:0]   mul_a;
    logic [W:0]     mul_b;
    logic [PW-1:0]  prod;
    logic [W-1:0]   prod_hi;
    logic [W+1:0]   rem2;
    logic           qbit;

    function automatic logic [W-1:0] sat(input logic [W:0] s);
        return s[W] ? '1 : s[W-1:0];
    endfunction

    assign b1      = {1'b1, {W{1'b0}}} - {1'b0, b0_q};
    assign sum     = {1'b0, u0_q} + {1'b0, u1_q};
    assign acc_sum = {1'b0, acc_q} + {1'b0, prod_hi};
    assign rem2    = {rem_q[W:0], 1'b0};
    assign qbit    = (rem2 >= {1'b0, sum});

    // Shared multiplier: operand selection follows the PRED/UPD step counter.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state_q == PRED) begin
            case (cnt_q[1:0])
                2'd0: begin mul_a = bus.trans[act_q][0][0]; mul_b = {1'b0, b0_q}; end
                2'd1: begin mul_a = bus.trans[act_q][1][0]; mul_b = b1;           end
                2'd2: begin mul_a = bus.trans[act_q][0][1]; mul_b = {1'b0, b0_q}; end
                default: begin mul_a = bus.trans[act_q][1][1]; mul_b = b1;        end
            endcase
        end else if (state_q == UPD) begin
            if (cnt_q[0] == 1'b0) begin
                mul_a = bus.observe[act_q][0][obs_q];
                mul_b = {1'b0, pred0_q};
            end else begin
                mul_a = bus.observe[act_q][1][obs_q];
                mul_b = {1'b0, pred1_q};
            end
        end
        prod    = PW'(mul_a) * PW'(mul_b);
        prod_hi = W'(prod >> W);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        act_d    = act_q;
        obs_d    = obs_q;
        b0_d     = b0_q;
        acc_d    = acc_q;
        pred0_d  = pred0_q;
        pred1_d  = pred1_q;
        u0_d     = u0_q;
        u1_d     = u1_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        belief_d = belief_q;
        valid_d  = 1'b0;
        degen_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.belief_load) begin
                    belief_d = bus.belief_init;
                end else if (bus.en_belief) begin
                    act_d   = (bus.action == 2'd3) ? 2'd2 : bus.action;
                    obs_d   = bus.observation;
                    b0_d    = belief_q;
                    cnt_d   = '0;
                    state_d = PRED;
                end
            end
            PRED: begin
                cnt_d = cnt_q + 1'b1;
                case (cnt_q[1:0])
                    2'd0: acc_d   = prod_hi;
                    2'd1: pred0_d = sat(acc_sum);
                    2'd2: acc_d   = prod_hi;
                    default: begin
                        pred1_d = sat(acc_sum);
                        cnt_d   = '0;
                        state_d = UPD;
                    end
                endcase
            end
            UPD: begin
                if (cnt_q[0] == 1'b0) begin
                    u0_d  = prod_hi;
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    u1_d    = prod_hi;
                    rem_d   = {2'b00, u0_q};
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                rem_d = qbit ? (rem2 - {1'b0, sum}) : rem2;
                quo_d = {quo_q[W-2:0], qbit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DIV_STEPS - 1)) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    // u1 == 0 means the quotient is exactly 1.0, which Q0.W cannot hold.
                    if (sum == '0)
                        degen_d = 1'b1;
                    else if (u1_q == '0)
                        belief_d = '1;
                    else
                        belief_d = {quo_q[W-2:0], qbit};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            act_q    <= '0;
            obs_q    <= 1'b0;
            b0_q     <= '0;
            acc_q    <= '0;
            pred0_q  <= '0;
            pred1_q  <= '0;
            u0_q     <= '0;
            u1_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            belief_q <= {1'b1, {(W-1){1'b0}}};
            valid_q  <= 1'b0;
            degen_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            act_q    <= act_d;
            obs_q    <= obs_d;
            b0_q     <= b0_d;
            acc_q    <= acc_d;
            pred0_q  <= pred0_d;
            pred1_q  <= pred1_d;
            u0_q     <= u0_d;
            u1_q     <= u1_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            belief_q <= belief_d;
            valid_q  <= valid_d;
            degen_q  <= degen_d;
        end
    end

    assign bus.belief_out   = belief_q;
    assign bus.belief_valid = valid_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.degenerate   = degen_q;
endmodule

// File: tb/tb_belief_update.sv
// Randomized and directed checks of belief_update against an arithmetic model
// of the Bayes update; outputs are sampled on the falling edge.
module tb_belief_update;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [15:0] T [0:2][0:1][0:1];
    logic [15:0] O [0:2][0:1][0:1];
    logic [15:0] model_belief;

    always #5 clk = ~clk;

    belief_update_if #(.W(16)) bus ();

    belief_update #(.W(16), .DIV_STEPS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_tables();
        for (int a = 0; a < 3; a++)
            for (int s = 0; s < 2; s++)
                for (int k = 0; k < 2; k++) begin
                    bus.trans[a][s][k]   = T[a][s][k];
                    bus.observe[a][s][k] = O[a][s][k];
                end
    endtask

    task automatic fill_tables(input logic [15:0] v);
        for (int a = 0; a < 3; a++)
            for (int s = 0; s < 2; s++)
                for (int k = 0; k < 2; k++) begin
                    T[a][s][k] = v;
                    O[a][s][k] = v;
                end
    endtask

    // Bayes rule on the two-state belief with floor-truncated Q0.16 products.
    function automatic logic [16:0] model(input logic [1:0] act, input logic o, input logic [15:0] b);
        int ai;
        longint b0, b1, p0, p1, u0, u1, s, q;
        ai = (act == 2'd3) ? 2 : int'(act);
        b0 = longint'(b);
        b1 = 65536 - b0;
        p0 = (longint'(T[ai][0][0]) * b0) / 65536 + (longint'(T[ai][1][0]) * b1) / 65536;
        p1 = (longint'(T[ai][0][1]) * b0) / 65536 + (longint'(T[ai][1][1]) * b1) / 65536;
        if (p0 > 65535) p0 = 65535;
        if (p1 > 65535) p1 = 65535;
        u0 = (longint'(O[ai][0][o]) * p0) / 65536;
        u1 = (longint'(O[ai][1][o]) * p1) / 65536;
        s  = u0 + u1;
        if (s == 0) return {1'b1, b};
        q = (u0 * 65536) / s;
        if (q > 65535) q = 65535;
        return {1'b0, q[15:0]};
    endfunction

    // Issue one request (sampled at edge N) and watch cycles N+1..N+24.
    task automatic run_update(input string tag, input logic [1:0] act, input logic o,
                              input logic [15:0] exp_b, input logic exp_d, input bit disturb);
        int valid_cnt, valid_at, busy_bad;
        logic d_seen;
        valid_cnt = 0; valid_at = -1; busy_bad = 0; d_seen = 1'b0;
        @(negedge clk);
        drive_tables();
        bus.action = act; bus.observation = o; bus.en_belief = 1'b1;
        @(posedge clk);
        #1 bus.en_belief = 1'b0;
        bus.action = 2'($urandom_range(0, 3)); bus.observation = 1'($urandom_range(0, 1));
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (disturb) begin
                bus.en_belief   = (c == 5);
                bus.belief_load = (c == 10);
                bus.belief_init = 16'h7777;
            end
            if (bus.busy !== ((c <= 22) ? 1'b1 : 1'b0)) busy_bad++;
            if (bus.belief_valid === 1'b1) begin
                valid_cnt++;
                if (valid_at < 0) valid_at = c;
                d_seen = bus.degenerate;
            end
        end
        bus.en_belief = 1'b0; bus.belief_load = 1'b0;
        check({tag, "_latency"}, 32'(valid_at), 32'd23);
        check({tag, "_valid_pulses"}, 32'(valid_cnt), 32'd1);
        check({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
        check({tag, "_belief"}, 32'(bus.belief_out), 32'(exp_b));
        check({tag, "_degenerate"}, 32'(d_seen), 32'(exp_d));
        model_belief = exp_b;
    endtask

    task automatic do_load(input logic [15:0] v, input logic with_en);
        @(negedge clk);
        bus.belief_load = 1'b1; bus.belief_init = v; bus.en_belief = with_en;
        @(posedge clk);
        #1 bus.belief_load = 1'b0; bus.en_belief = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("load_busy", 32'(bus.busy), 32'd0);
        end
        check("load_value", 32'(bus.belief_out), 32'(v));
        check("load_no_valid", 32'(bus.belief_valid), 32'd0);
        model_belief = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [16:0] r;
        logic [1:0]  ra;
        logic        ro;
        bus.en_belief = 1'b0; bus.action = '0; bus.observation = 1'b0;
        bus.belief_load = 1'b0; bus.belief_init = '0;
        fill_tables(16'h8000);
        drive_tables();
        model_belief = 16'h8000;
        #23;
        check("rst_belief", 32'(bus.belief_out), 32'h8000);
        check("rst_valid", 32'(bus.belief_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_degenerate", 32'(bus.degenerate), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_update("uniform", 2'd2, 1'b0, 16'h8000, 1'b0, 1'b0);

        fill_tables(16'h0000);
        T[2][0][0] = 16'hFFFF; T[2][1][1] = 16'hFFFF;
        O[2][0][1] = 16'hC000; O[2][1][1] = 16'h4000;
        run_update("identity", 2'd2, 1'b1, 16'hC001, 1'b0, 1'b0);

        do_load(16'h1234, 1'b0);
        fill_tables(16'h8000);
        O[1][0][0] = 16'h0000; O[1][1][0] = 16'h0000;
        run_update("degen", 2'd1, 1'b0, 16'h1234, 1'b1, 1'b0);

        fill_tables(16'h8000);
        O[0][1][1] = 16'h0000;
        run_update("saturate", 2'd0, 1'b1, 16'hFFFF, 1'b0, 1'b0);

        fill_tables(16'h8000);
        r = model(2'd3, 1'b0, model_belief);
        run_update("ignore_busy", 2'd3, 1'b0, r[15:0], r[16], 1'b1);
        do_load(16'h2000, 1'b1);

        @(negedge clk);
        bus.en_belief = 1'b1; bus.action = 2'd0;
        @(posedge clk);
        #1 bus.en_belief = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_belief", 32'(bus.belief_out), 32'h8000);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        begin
            int v = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (bus.belief_valid === 1'b1) v++;
            end
            check("midrst_no_valid", 32'(v), 32'd0);
        end
        model_belief = 16'h8000;
        r = model(2'd0, 1'b1, model_belief);
        run_update("post_rst", 2'd0, 1'b1, r[15:0], r[16], 1'b0);

        for (int it = 0; it < 30; it++) begin
            ra = 2'($urandom_range(0, 3));
            ro = 1'($urandom_range(0, 1));
            for (int a = 0; a < 3; a++)
                for (int s = 0; s < 2; s++)
                    for (int k = 0; k < 2; k++) begin
                        T[a][s][k] = 16'($urandom_range(0, 65535));
                        O[a][s][k] = 16'($urandom_range(0, 65535));
                    end
            if ($urandom_range(0, 7) == 0) begin
                O[(ra == 2'd3) ? 2 : ra][0][ro] = 16'h0000;
                O[(ra == 2'd3) ? 2 : ra][1][ro] = 16'h0000;
            end
            if ($urandom_range(0, 4) == 0)
                do_load(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
            r = model(ra, ro, model_belief);
            run_update("rand", ra, ro, r[15:0], r[16], 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
